logic_fu_pipe: RTL and testbench

- Two-stage pipelined logical functional unit for the out-of-order core's integer execution cluster.
- Accepts issued ops (opcode, ROB tag, two 64-bit operands) from the reservation station with a valid/ready handshake.
- Computes a bitwise result (NOR, AND, OR, XOR and variants) and drives the common data bus (CDB) arbiter through a valid/ready output.
- Supports full back-pressure and a pipeline flush on branch mispredict.

---
 rtl/logic_fu_pkg.sv | 32 +++
 rtl/logic_unit_comb.sv | 32 +++
 rtl/logic_fu_pipe.sv | 102 ++++++++++
 tb/tb_logic_fu_pipe.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/logic_fu_pkg.sv
// Shared types for the logical functional unit: opcode encoding and the
// per-stage payload layouts of the two-stage pipeline.
package logic_fu_pkg;

  localparam int XLEN_DEF  = 64;
  localparam int TAG_W_DEF = 6;

  typedef enum logic [2:0] {
    OP_AND   = 3'd0,
    OP_OR    = 3'd1,
    OP_XOR   = 3'd2,
    OP_NOR   = 3'd3,
    OP_NAND  = 3'd4,
    OP_XNOR  = 3'd5,
    OP_ANDN  = 3'd6,
    OP_PASSA = 3'd7
  } logic_op_e;

  typedef struct packed {
    logic_op_e              op;
    logic [TAG_W_DEF-1:0]   tag;
    logic [XLEN_DEF-1:0]    a;
    logic [XLEN_DEF-1:0]    b;
  } s1_entry_t;

  typedef struct packed {
    logic [TAG_W_DEF-1:0]   tag;
    logic [XLEN_DEF-1:0]    result;
    logic                   zero;
  } s2_entry_t;

endpackage

// File: rtl/logic_unit_comb.sv
// Purely combinational bitwise datapath: evaluates the opcode on two operands
// and flags an all-zero result.
module logic_unit_comb
  import logic_fu_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic_op_e       op_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output logic [XLEN-1:0] result_o,
  output logic            zero_o
);

  always_comb begin
    result_o = a_i;
    case (op_i)
      OP_AND:   result_o = a_i & b_i;
      OP_OR:    result_o = a_i | b_i;
      OP_XOR:   result_o = a_i ^ b_i;
      OP_NOR:   result_o = ~(a_i | b_i);
      OP_NAND:  result_o = ~(a_i & b_i);
      OP_XNOR:  result_o = ~(a_i ^ b_i);
      OP_ANDN:  result_o = a_i & ~b_i;
      OP_PASSA: result_o = a_i;
      default:  result_o = a_i;
    endcase
  end

  assign zero_o = (result_o == '0);

endmodule

// File: rtl/logic_fu_pipe.sv
// Two-stage logical functional unit: S1 registers the issued operands, S2
// registers the result for the CDB, with back-pressure and mispredict flush.
module logic_fu_pipe
  import logic_fu_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int TAG_W = TAG_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [TAG_W-1:0] in_tag,
  input  logic [XLEN-1:0]  in_a,
  input  logic [XLEN-1:0]  in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [TAG_W-1:0] out_tag,
  output logic [XLEN-1:0]  out_result,
  output logic             out_zero,
  output logic             busy
);

  logic      s1_valid_q, s1_valid_d;
  logic      s2_valid_q, s2_valid_d;
  s1_entry_t s1_q, s1_d;
  s2_entry_t s2_q, s2_d;

  logic            s2_adv;
  logic            accept;
  logic            s1_move;
  logic [XLEN-1:0] alu_result;
  logic            alu_zero;

  logic_unit_comb #(
    .XLEN(XLEN)
  ) u_logic_unit (
    .op_i     (s1_q.op),
    .a_i      (s1_q.a),
    .b_i      (s1_q.b),
    .result_o (alu_result),
    .zero_o   (alu_zero)
  );

  assign s2_adv   = !s2_valid_q || out_ready;
  // Reset is folded in so the issue slot sees no acceptance during the reset cycle.
  assign in_ready = !reset && !flush && (!s1_valid_q || s2_adv);
  assign accept   = in_valid && in_ready;
  assign s1_move  = s1_valid_q && s2_adv && !flush;

  always_comb begin
    s1_valid_d = s1_valid_q;
    s2_valid_d = s2_valid_q;
    s1_d       = s1_q;
    s2_d       = s2_q;
    if (flush) begin
      s1_valid_d = 1'b0;
      s2_valid_d = 1'b0;
    end else begin
      if (s1_move) begin
        s2_valid_d  = 1'b1;
        s2_d.tag    = s1_q.tag;
        s2_d.result = alu_result;
        s2_d.zero   = alu_zero;
      end else if (out_ready) begin
        s2_valid_d = 1'b0;
      end
      if (accept) begin
        s1_valid_d = 1'b1;
        s1_d.op    = logic_op_e'(in_op);
        s1_d.tag   = in_tag;
        s1_d.a     = in_a;
        s1_d.b     = in_b;
      end else if (s1_move) begin
        s1_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      s1_q       <= '0;
      s2_q       <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      s1_q       <= s1_d;
      s2_q       <= s2_d;
    end
  end

  assign out_valid  = s2_valid_q;
  assign out_tag    = s2_q.tag;
  assign out_result = s2_q.result;
  assign out_zero   = s2_q.zero;
  assign busy       = s1_valid_q | s2_valid_q;

endmodule

// File: tb/tb_logic_fu_pipe.sv
// Directed and randomized checks of logic_fu_pipe against an in-order
// queue model of issued ops and their bitwise results.
module tb_logic_fu_pipe;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_op;
  logic [5:0]  in_tag;
  logic [63:0] in_a;
  logic [63:0] in_b;
  logic        out_valid;
  logic        out_ready;
  logic [5:0]  out_tag;
  logic [63:0] out_result;
  logic        out_zero;
  logic        busy;

  logic_fu_pipe dut (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_tag     (in_tag),
    .in_a       (in_a),
    .in_b       (in_b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_tag    (out_tag),
    .out_result (out_result),
    .out_zero   (out_zero),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]  tag;
    logic [63:0] res;
    logic        zero;
  } exp_t;

  exp_t q[$];
  int   vectors     = 0;
  int   miscompares = 0;
  int   exp_ov      = -1;
  bit   check_en    = 0;
  bit   zero_chk    = 0;

  function automatic logic [63:0] ref_op(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b);
    case (op)
      3'd0:    return a & b;
      3'd1:    return a | b;
      3'd2:    return a ^ b;
      3'd3:    return ~(a | b);
      3'd4:    return ~(a & b);
      3'd5:    return ~(a ^ b);
      3'd6:    return a & ~b;
      default: return a;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  // One clock: check outputs mid-cycle, then advance the model at the edge.
  task automatic cycle();
    logic        exp_rdy;
    logic        acc;
    logic        ret;
    logic [63:0] r;
    #4;
    exp_rdy = !reset && !flush && (q.size() < 2 || out_ready);
    if (check_en) begin
      chk("in_ready", 64'(in_ready), 64'(exp_rdy));
      chk("busy", 64'(busy), 64'(q.size() != 0));
      if (exp_ov >= 0) chk("out_valid", 64'(out_valid), 64'(exp_ov[0]));
      if (q.size() == 0) chk("out_valid_empty", 64'(out_valid), 64'd0);
      else if (out_valid) begin
        chk("out_tag", 64'(out_tag), 64'(q[0].tag));
        chk("out_result", out_result, q[0].res);
        chk("out_zero", 64'(out_zero), 64'(q[0].zero));
      end
      if (zero_chk) begin
        chk("rst_out_tag", 64'(out_tag), 64'd0);
        chk("rst_out_result", out_result, 64'd0);
        chk("rst_out_zero", 64'(out_zero), 64'd0);
        zero_chk = 0;
      end
    end
    acc = in_valid && exp_rdy;
    ret = out_valid && out_ready && (q.size() > 0);
    r   = ref_op(in_op, in_a, in_b);
    @(posedge clk);
    if (reset) begin
      q.delete();
      zero_chk = 1;
    end else if (flush) begin
      q.delete();
    end else begin
      if (ret) void'(q.pop_front());
      if (acc) q.push_back('{tag: in_tag, res: r, zero: (r == 64'd0)});
    end
    exp_ov = -1;
    #1;
  endtask

  task automatic issue(input logic [2:0] op, input logic [5:0] tag, input logic [63:0] a, input logic [63:0] b);
    in_valid = 1'b1;
    in_op    = op;
    in_tag   = tag;
    in_a     = a;
    in_b     = b;
  endtask

  task automatic drain(input int budget);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < budget && q.size() != 0; i++) cycle();
    chk("drain_complete", 64'(q.size()), 64'd0);
    cycle();
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_op = 3'd0; in_tag = 6'd0; in_a = 64'd0; in_b = 64'd0;
    @(posedge clk); #1;
    cycle();
    check_en = 1;
    cycle();
    reset = 1'b0;
    exp_ov = 0;
    cycle();

    // Basic NOR with 2-cycle latency
    out_ready = 1'b1;
    issue(3'd3, 6'd3, 64'h5555_5555_5555_5555, 64'h5555_5555_5555_5555);
    exp_ov = 0; cycle();
    in_valid = 1'b0;
    exp_ov = 0; cycle();
    exp_ov = 1; cycle();
    exp_ov = 0; cycle();

    // Zero flag cases
    issue(3'd3, 6'd4, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0);
    cycle();
    issue(3'd2, 6'd5, 64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5555);
    cycle();
    drain(10);

    // Streaming: all opcodes back to back
    for (int k = 0; k <= 10; k++) begin
      if (k < 8) issue(k[2:0], k[5:0], 64'hF0F0_F0F0_F0F0_F0F0, 64'hFF00_FF00_FF00_FF00);
      else in_valid = 1'b0;
      exp_ov = (k >= 2 && k <= 9) ? 1 : 0;
      cycle();
    end

    // Back-pressure with tag 3 pending
    out_ready = 1'b0;
    issue(3'd1, 6'd1, 64'h1234_5678_9ABC_DEF0, 64'h0F0F_0000_FFFF_0001);
    cycle();
    issue(3'd6, 6'd2, 64'hFFFF_0000_FFFF_0000, 64'h00FF_00FF_00FF_00FF);
    cycle();
    issue(3'd5, 6'd3, 64'hDEAD_BEEF_0000_0001, 64'hDEAD_BEEF_0000_0001);
    for (int k = 0; k < 3; k++) begin
      exp_ov = 1;
      cycle();
    end
    out_ready = 1'b1;
    exp_ov = 1; cycle();
    drain(10);

    // Flush with two in flight and a colliding issue
    out_ready = 1'b0;
    issue(3'd0, 6'd10, 64'hFFFF_FFFF_0000_0000, 64'hFFFF_0000_FFFF_0000);
    cycle();
    issue(3'd4, 6'd11, 64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210);
    cycle();
    issue(3'd7, 6'd12, 64'hCAFE_0000_0000_CAFE, 64'd0);
    flush = 1'b1;
    cycle();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    exp_ov = 0; cycle();
    issue(3'd2, 6'd13, 64'h0000_0000_0000_00FF, 64'h0000_0000_0000_000F);
    exp_ov = 0; cycle();
    in_valid = 1'b0;
    exp_ov = 0; cycle();
    exp_ov = 1; cycle();
    exp_ov = 0; cycle();

    // Reset with both stages full and output stalled
    out_ready = 1'b0;
    issue(3'd1, 6'd20, 64'h8000_0000_0000_0000, 64'h1);
    cycle();
    issue(3'd0, 6'd21, 64'hFFFF_FFFF_FFFF_FFFF, 64'h7);
    cycle();
    in_valid = 1'b0;
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    exp_ov = 0; cycle();

    // Randomized traffic with occasional flush
    for (int i = 0; i < 600; i++) begin
      logic [63:0] ra;
      ra = {$urandom, $urandom};
      issue(3'($urandom_range(0, 7)), 6'($urandom_range(0, 63)), ra,
            ($urandom_range(0, 7) == 0) ? ra : {$urandom, $urandom});
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 39) == 0);
      cycle();
    end
    flush = 1'b0;
    drain(20);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
